// File: rtl/occ_line_fetch.sv
// occ_line_fetch: occurrence-line fetch responder for the backward-extension stage.
// Buffers up to DEPTH {addr_k, addr_l, token} requests, issues the two line
// reads per request on one in-order memory read port, pairs the returned lines
// with their token and hands them downstream in request order.
//
// Optional feature macro: SAME_LINE_MERGE_EN
//   defined   - an entry with addr_k == addr_l issues a single read; the one
//               response fills both out_line_k and out_line_l.
//   undefined - every entry issues two reads.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/addr_k/addr_l/token   request beat from the upstream stage
//   req_full            buffer holds DEPTH entries (upstream must stall)
//   err_overflow        sticky: a beat arrived while req_full was high
//   mem_rd_valid/addr/ready         read command channel
//   mem_rsp_valid/data/ready        read response channel (in command order)
//   out_valid/ready, out_line_k/l, out_token   paired result to the count stage
module occ_line_fetch #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned ADDR_W  = 42,
    parameter int unsigned TOKEN_W = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr_k,
    input  logic [ADDR_W-1:0]  req_addr_l,
    input  logic [TOKEN_W-1:0] req_token,
    output logic               req_full,
    output logic               err_overflow,
    output logic               mem_rd_valid,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic               mem_rd_ready,
    input  logic               mem_rsp_valid,
    input  logic [DATA_W-1:0]  mem_rsp_data,
    output logic               mem_rsp_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_line_k,
    output logic [DATA_W-1:0]  out_line_l,
    output logic [TOKEN_W-1:0] out_token
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef struct packed {
`ifdef SAME_LINE_MERGE_EN
        logic               same;
`endif
        logic [ADDR_W-1:0]  addr_k;
        logic [ADDR_W-1:0]  addr_l;
        logic [TOKEN_W-1:0] token;
    } entry_t;

    typedef enum logic [1:0] {I_IDLE, I_K, I_L} iss_state_t;
    typedef enum logic [1:0] {C_K, C_L, C_OUT} col_state_t;

    entry_t     entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] iss_ptr;
    logic [PTR_W-1:0] ret_ptr;
    iss_state_t iss_state;
    col_state_t col_state;

    logic             wr_en_c;
    logic             pop_c;
    logic             iss_hs_c;
    logic             rsp_hs_c;
    logic             more_c;
    logic [PTR_W-1:0] iss_nxt_c;
    logic [PTR_W-1:0] cnt_nxt_c;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] iss_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] ret_idx;

    // Handshakes, pointer look-ahead and next occupancy
    always_comb begin
        wr_en_c   = req_valid & ~req_full;
        pop_c     = out_valid & out_ready;
        iss_hs_c  = mem_rd_valid & mem_rd_ready;
        rsp_hs_c  = mem_rsp_valid & mem_rsp_ready;
        iss_nxt_c = iss_ptr + PTR_W'(1);
        more_c    = (iss_nxt_c != wr_ptr);
        cnt_nxt_c = (wr_ptr + PTR_W'(wr_en_c)) - (ret_ptr + PTR_W'(pop_c));
        wr_idx    = wr_ptr[IDX_W-1:0];
        iss_idx   = iss_ptr[IDX_W-1:0];
        nxt_idx   = iss_nxt_c[IDX_W-1:0];
        ret_idx   = ret_ptr[IDX_W-1:0];
    end

    // Request storage (no reset needed: pointers qualify every read)
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
`ifdef SAME_LINE_MERGE_EN
            entries[wr_idx].same <= (req_addr_k == req_addr_l);
`endif
            entries[wr_idx].addr_k <= req_addr_k;
            entries[wr_idx].addr_l <= req_addr_l;
            entries[wr_idx].token  <= req_token;
        end
    end

    // Write pointer, full flag and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            req_full     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (req_valid && req_full) begin
                err_overflow <= 1'b1;
            end
            req_full <= (cnt_nxt_c == PTR_W'(DEPTH));
        end
    end

    // Issue FSM: K then L command per entry, held stable until accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_state    <= I_IDLE;
            iss_ptr      <= '0;
            mem_rd_valid <= 1'b0;
            mem_rd_addr  <= '0;
        end else begin
            case (iss_state)
                I_IDLE: begin
                    if (iss_ptr != wr_ptr) begin
                        iss_state    <= I_K;
                        mem_rd_valid <= 1'b1;
                        mem_rd_addr  <= entries[iss_idx].addr_k;
                    end
                end
                I_K: begin
                    if (iss_hs_c) begin
`ifdef SAME_LINE_MERGE_EN
                        if (entries[iss_idx].same) begin
                            iss_ptr <= iss_nxt_c;
                            if (more_c) begin
                                mem_rd_addr <= entries[nxt_idx].addr_k;
                            end else begin
                                iss_state    <= I_IDLE;
                                mem_rd_valid <= 1'b0;
                            end
                        end else
`endif
                        begin
                            iss_state   <= I_L;
                            mem_rd_addr <= entries[iss_idx].addr_l;
                        end
                    end
                end
                I_L: begin
                    if (iss_hs_c) begin
                        iss_ptr <= iss_nxt_c;
                        // Chain straight into the next entry's K read when one is waiting
                        if (more_c) begin
                            iss_state   <= I_K;
                            mem_rd_addr <= entries[nxt_idx].addr_k;
                        end else begin
                            iss_state    <= I_IDLE;
                            mem_rd_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    iss_state    <= I_IDLE;
                    mem_rd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Collect FSM: capture K and L lines, present result, wait for pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_state     <= C_K;
            ret_ptr       <= '0;
            mem_rsp_ready <= 1'b0;
            out_valid     <= 1'b0;
            out_line_k    <= '0;
            out_line_l    <= '0;
            out_token     <= '0;
        end else begin
            case (col_state)
                C_K: begin
                    mem_rsp_ready <= 1'b1;
                    if (rsp_hs_c) begin
                        out_line_k <= mem_rsp_data;
`ifdef SAME_LINE_MERGE_EN
                        if (entries[ret_idx].same) begin
                            out_line_l    <= mem_rsp_data;
                            out_token     <= entries[ret_idx].token;
                            out_valid     <= 1'b1;
                            mem_rsp_ready <= 1'b0;
                            col_state     <= C_OUT;
                        end else
`endif
                        begin
                            col_state <= C_L;
                        end
                    end
                end
                C_L: begin
                    mem_rsp_ready <= 1'b1;
                    if (rsp_hs_c) begin
                        out_line_l    <= mem_rsp_data;
                        out_token     <= entries[ret_idx].token;
                        out_valid     <= 1'b1;
                        mem_rsp_ready <= 1'b0;
                        col_state     <= C_OUT;
                    end
                end
                C_OUT: begin
                    if (pop_c) begin
                        out_valid     <= 1'b0;
                        ret_ptr       <= ret_ptr + PTR_W'(1);
                        mem_rsp_ready <= 1'b1;
                        col_state     <= C_K;
                    end
                end
                default: begin
                    col_state <= C_K;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_occ_line_fetch.sv
// Directed self-checking bench for occ_line_fetch with a small in-order
// memory model (configurable latency) and output/command loggers.
module tb_occ_line_fetch;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DATA_W  = 512;
    localparam int unsigned ADDR_W  = 42;
    localparam int unsigned TOKEN_W = 256;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic [ADDR_W-1:0]  req_addr_k;
    logic [ADDR_W-1:0]  req_addr_l;
    logic [TOKEN_W-1:0] req_token;
    logic               req_full;
    logic               err_overflow;
    logic               mem_rd_valid;
    logic [ADDR_W-1:0]  mem_rd_addr;
    logic               mem_rd_ready;
    logic               mem_rsp_valid;
    logic [DATA_W-1:0]  mem_rsp_data;
    logic               mem_rsp_ready;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_line_k;
    logic [DATA_W-1:0]  out_line_l;
    logic [TOKEN_W-1:0] out_token;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rnd_en   = 1'b0;
    int rsp_lat  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        int                t;
    } cmd_t;
    typedef struct packed {
        logic [DATA_W-1:0]  k;
        logic [DATA_W-1:0]  l;
        logic [TOKEN_W-1:0] tok;
    } res_t;

    cmd_t              cmd_q[$];
    logic [ADDR_W-1:0] cmd_log[$];
    res_t              out_q[$];

    occ_line_fetch #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TOKEN_W(TOKEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr_k(req_addr_k), .req_addr_l(req_addr_l),
        .req_token(req_token), .req_full(req_full), .err_overflow(err_overflow),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_line_k(out_line_k),
        .out_line_l(out_line_l), .out_token(out_token)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < int'(DATA_W / 32); i++) d[i*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 + 32'(i));
        return d;
    endfunction

    function automatic logic [TOKEN_W-1:0] mk_tok(input int n);
        logic [TOKEN_W-1:0] t;
        for (int j = 0; j < int'(TOKEN_W / 32); j++) t[j*32 +: 32] = 32'hC000_0000 ^ (32'(n) << 8) ^ 32'(j);
        return t;
    endfunction

    // Loggers: sample handshakes with pre-edge values
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (mem_rsp_valid && mem_rsp_ready && cmd_q.size() > 0) void'(cmd_q.pop_front());
            if (mem_rd_valid && mem_rd_ready) begin
                cmd_q.push_back('{addr: mem_rd_addr, t: cyc});
                cmd_log.push_back(mem_rd_addr);
            end
            if (out_valid && out_ready) out_q.push_back('{k: out_line_k, l: out_line_l, tok: out_token});
        end
    end

    // Memory responder (honours mem_rsp_ready) and optional random readies
    always @(negedge clk) begin
        if (rnd_en) begin
            mem_rd_ready = ($urandom_range(0, 2) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
        end
        if (rst && mem_rsp_ready && cmd_q.size() > 0 && cyc >= cmd_q[0].t + rsp_lat - 1) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mk_data(cmd_q[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; mem_rd_ready = 1'b0; out_ready = 1'b0;
        cmd_q.delete(); cmd_log.delete(); out_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_req(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l,
                            input logic [TOKEN_W-1:0] tok, input bit force_beat);
        int w = 0;
        while (!force_beat && req_full && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            n_checks++; n_fail++;
            $display("FAIL send_req_stall: req_full stuck at %0b", req_full);
        end
        req_valid = 1'b1; req_addr_k = k; req_addr_l = l; req_token = tok;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int limit, output bit ok);
        int t = 0;
        while (out_q.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        ok = (out_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_rd_valid, mem_rsp_ready, out_valid, req_full, err_overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got rdv=%b rspr=%b ov=%b full=%b ovf=%b, required all 0",
                     mem_rd_valid, mem_rsp_ready, out_valid, req_full, err_overflow);
        end
        n_checks++;
        if (mem_rd_addr !== '0 || out_line_k !== '0 || out_line_l !== '0 || out_token !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h k=%h tok=%h, required 0",
                     mem_rd_addr, out_line_k[63:0], out_token[63:0]);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_rsp_ready !== 1'b1 || mem_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rspr=%b rdv=%b, required 1 0", mem_rsp_ready, mem_rd_valid);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [TOKEN_W-1:0] tok;
        apply_reset();
        mem_rd_ready = 1'b1; out_ready = 1'b1; rsp_lat = 3;
        tok = mk_tok(1);
        send_req(42'h100, 42'h240, tok, 1'b0);
        @(negedge clk);
        n_checks++;
        if (mem_rd_valid !== 1'b1 || mem_rd_addr !== 42'h100) begin
            n_fail++;
            $display("FAIL single_cmd_k: got v=%b addr=%h, required 1 100", mem_rd_valid, mem_rd_addr);
        end
        @(negedge clk);
        n_checks++;
        if (mem_rd_valid !== 1'b1 || mem_rd_addr !== 42'h240) begin
            n_fail++;
            $display("FAIL single_cmd_l: got v=%b addr=%h, required 1 240", mem_rd_valid, mem_rd_addr);
        end
        wait_outs(1, 50, ok);
        n_checks++;
        if (!ok || cmd_log.size() != 2) begin
            n_fail++;
            $display("FAIL single_done: got outs=%0d cmds=%0d, required 1 2", out_q.size(), cmd_log.size());
        end else begin
            n_checks++;
            if (cmd_log[0] !== 42'h100 || cmd_log[1] !== 42'h240) begin
                n_fail++;
                $display("FAIL single_cmd_order: got %h %h, required 100 240", cmd_log[0], cmd_log[1]);
            end
            n_checks++;
            if (out_q[0].k !== mk_data(42'h100) || out_q[0].l !== mk_data(42'h240) || out_q[0].tok !== tok) begin
                n_fail++;
                $display("FAIL single_result: got k=%h l=%h tok=%h, required k=%h l=%h tok=%h",
                         out_q[0].k[63:0], out_q[0].l[63:0], out_q[0].tok[63:0],
                         mk_data(42'h100) & 64'hFFFF_FFFF_FFFF_FFFF, mk_data(42'h240) & 64'hFFFF_FFFF_FFFF_FFFF,
                         tok[63:0]);
            end
        end
    endtask

    task automatic test_full_overflow();
        bit ok;
        logic [ADDR_W-1:0] ek, el;
        apply_reset();
        mem_rd_ready = 1'b0; out_ready = 1'b1; rsp_lat = 3;
        for (int i = 0; i < 8; i++) begin
            send_req(42'h2000 + ADDR_W'(i * 64), 42'h4000 + ADDR_W'(i * 64), mk_tok(10 + i), 1'b0);
            if (i == 6) begin
                n_checks++;
                if (req_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early: got req_full=%b after 7 accepts, required 0", req_full);
                end
            end
        end
        n_checks++;
        if (req_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_set: got req_full=%b after 8 accepts, required 1", req_full);
        end
        send_req(42'hDEAD, 42'hBEEF, mk_tok(99), 1'b1);
        n_checks++;
        if (err_overflow !== 1'b1 || req_full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flag: got ovf=%b full=%b, required 1 1", err_overflow, req_full);
        end
        n_checks++;
        if (mem_rd_valid !== 1'b1 || mem_rd_addr !== 42'h2000) begin
            n_fail++;
            $display("FAIL overflow_hold: got v=%b addr=%h, required 1 2000", mem_rd_valid, mem_rd_addr);
        end
        mem_rd_ready = 1'b1;
        wait_outs(8, 300, ok);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!ok || out_q.size() != 8 || cmd_log.size() != 16) begin
            n_fail++;
            $display("FAIL drain_count: got outs=%0d cmds=%0d, required 8 16", out_q.size(), cmd_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                ek = 42'h2000 + ADDR_W'(i * 64);
                el = 42'h4000 + ADDR_W'(i * 64);
                n_checks++;
                if (out_q[i].k !== mk_data(ek) || out_q[i].l !== mk_data(el) || out_q[i].tok !== mk_tok(10 + i)) begin
                    n_fail++;
                    $display("FAIL drain_order[%0d]: got tok=%h, required tok=%h", i,
                             out_q[i].tok[63:0], mk_tok(10 + i) & 256'hFFFF_FFFF_FFFF_FFFF);
                end
            end
        end
        n_checks++;
        if (req_full !== 1'b0 || err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_flags: got full=%b ovf=%b, required 0 1", req_full, err_overflow);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int t = 0;
        apply_reset();
        mem_rd_ready = 1'b1; out_ready = 1'b0; rsp_lat = 2;
        for (int i = 0; i < 3; i++)
            send_req(42'h3000 + ADDR_W'(i * 64), 42'h5000 + ADDR_W'(i * 64), mk_tok(20 + i), 1'b0);
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_valid: got out_valid=%b, required 1", out_valid);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || mem_rsp_ready !== 1'b0 || out_line_k !== mk_data(42'h3000) ||
                out_line_l !== mk_data(42'h5000) || out_token !== mk_tok(20)) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ov=%b rspr=%b tok=%h, required 1 0 %h", c, out_valid,
                         mem_rsp_ready, out_token[63:0], mk_tok(20) & 256'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        n_checks++;
        if (cmd_log.size() != 6) begin
            n_fail++;
            $display("FAIL bp_cmds: got %0d commands, required 6", cmd_log.size());
        end
        out_ready = 1'b1;
        wait_outs(3, 100, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_release: got %0d results, required 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (out_q[i].k !== mk_data(42'h3000 + ADDR_W'(i * 64)) ||
                    out_q[i].l !== mk_data(42'h5000 + ADDR_W'(i * 64)) || out_q[i].tok !== mk_tok(20 + i)) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got tok=%h, required %h", i, out_q[i].tok[63:0],
                             mk_tok(20 + i) & 256'hFFFF_FFFF_FFFF_FFFF);
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad = 0;
        apply_reset();
        rsp_lat = 2;
        rnd_en = 1'b1;
        for (int i = 0; i < 40; i++)
            send_req(42'h10000 + ADDR_W'(i * 64), 42'h20000 + ADDR_W'(i * 128), mk_tok(100 + i), 1'b0);
        wait_outs(40, 4000, ok);
        rnd_en = 1'b0;
        n_checks++;
        if (!ok || cmd_log.size() != 80) begin
            n_fail++;
            $display("FAIL wrap_count: got outs=%0d cmds=%0d, required 40 80", out_q.size(), cmd_log.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                n_checks++;
                if (cmd_log[2*i] !== 42'h10000 + ADDR_W'(i * 64) || cmd_log[2*i+1] !== 42'h20000 + ADDR_W'(i * 128) ||
                    out_q[i].k !== mk_data(42'h10000 + ADDR_W'(i * 64)) ||
                    out_q[i].l !== mk_data(42'h20000 + ADDR_W'(i * 128)) || out_q[i].tok !== mk_tok(100 + i)) begin
                    n_fail++;
                    bad++;
                    $display("FAIL wrap_entry[%0d]: got cmd_k=%h tok=%h, required cmd_k=%h", i, cmd_log[2*i],
                             out_q[i].tok[63:0], 42'h10000 + ADDR_W'(i * 64));
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        apply_reset();
        mem_rd_ready = 1'b0; out_ready = 1'b1; rsp_lat = 3;
        for (int i = 0; i < 3; i++)
            send_req(42'h6000 + ADDR_W'(i * 64), 42'h7000 + ADDR_W'(i * 64), mk_tok(50 + i), 1'b0);
        mem_rd_ready = 1'b1;
        @(negedge clk);
        mem_rd_ready = 1'b0;
        n_checks++;
        if (mem_rd_valid !== 1'b1 || mem_rd_addr !== 42'h7000) begin
            n_fail++;
            $display("FAIL mid_in_l: got v=%b addr=%h, required 1 7000", mem_rd_valid, mem_rd_addr);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_rd_valid, mem_rsp_ready, out_valid, req_full, err_overflow} !== 5'b0 ||
            mem_rd_addr !== '0 || out_line_k !== '0 || out_line_l !== '0 || out_token !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdv=%b rspr=%b ov=%b full=%b addr=%h, required all 0",
                     mem_rd_valid, mem_rsp_ready, out_valid, req_full, mem_rd_addr);
        end
        cmd_q.delete(); cmd_log.delete(); out_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_full !== 1'b0 || mem_rsp_ready !== 1'b1 || mem_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: got full=%b rspr=%b rdv=%b, required 0 1 0",
                     req_full, mem_rsp_ready, mem_rd_valid);
        end
        mem_rd_ready = 1'b1;
        send_req(42'h8000, 42'h8040, mk_tok(60), 1'b0);
        wait_outs(1, 60, ok);
        n_checks++;
        if (!ok || cmd_log.size() != 2) begin
            n_fail++;
            $display("FAIL mid_recover: got outs=%0d cmds=%0d, required 1 2", out_q.size(), cmd_log.size());
        end else if (out_q[0].k !== mk_data(42'h8000) || out_q[0].l !== mk_data(42'h8040) ||
                     out_q[0].tok !== mk_tok(60)) begin
            n_fail++;
            $display("FAIL mid_recover_data: got tok=%h, required %h", out_q[0].tok[63:0],
                     mk_tok(60) & 256'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_same_line();
        bit ok;
        int exp_cmds;
`ifdef SAME_LINE_MERGE_EN
        exp_cmds = 1;
`else
        exp_cmds = 2;
`endif
        apply_reset();
        mem_rd_ready = 1'b1; out_ready = 1'b1; rsp_lat = 3;
        send_req(42'h3C0, 42'h3C0, mk_tok(70), 1'b0);
        wait_outs(1, 60, ok);
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok || cmd_log.size() != exp_cmds) begin
            n_fail++;
            $display("FAIL same_cmds: got outs=%0d cmds=%0d, required 1 %0d", out_q.size(), cmd_log.size(), exp_cmds);
        end else begin
            n_checks++;
            if (out_q[0].k !== mk_data(42'h3C0) || out_q[0].l !== mk_data(42'h3C0) || out_q[0].tok !== mk_tok(70)) begin
                n_fail++;
                $display("FAIL same_data: got k=%h l=%h, required %h", out_q[0].k[63:0], out_q[0].l[63:0],
                         mk_data(42'h3C0) & 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr_k = '0; req_addr_l = '0; req_token = '0;
        mem_rd_ready = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_full_overflow();
        test_backpressure();
        test_wrap();
        test_reset_midflight();
        test_same_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/occ_line_fetch.md
# occ_line_fetch

Responder for the backward-extension stage's occurrence-line requests. It accepts {addr_k, addr_l, token} request beats and issues the two line reads on a single in-order memory read port. It pairs the two returned 512-bit lines with their token and hands them to the occurrence-count stage in request order. It buffers up to DEPTH outstanding requests and back-pressures the requesting stage through `req_full`.

## Interface
- DEPTH, 8: request-buffer entries; power of two, 2..64
- DATA_W, 512: memory line width
- ADDR_W, 42: memory line address width
- TOKEN_W, 256: packed pass-through token width (read_num, status, backward_k/l, backward_i/j, ...)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  1  request beat; driven by upstream `request_valid & !stall`
- req_addr_k  in  ADDR_W  line address for k
- req_addr_l  in  ADDR_W  line address for l
- req_token  in  TOKEN_W  token carried with the request
- req_full  out  1  buffer holds DEPTH entries; upstream must stall
- err_overflow  out  1  sticky; set when a request beat arrives while `req_full` is high
- mem_rd_valid  out  1  read command valid
- mem_rd_addr  out  ADDR_W  read command address
- mem_rd_ready  in  1  memory accepts the command
- mem_rsp_valid  in  1  read data valid; responses return in command order
- mem_rsp_data  in  DATA_W  read data
- mem_rsp_ready  out  1  collector can accept a response
- out_valid  out  1  paired result valid
- out_ready  in  1  downstream accepts the result
- out_line_k  out  DATA_W  line returned for addr_k
- out_line_l  out  DATA_W  line returned for addr_l
- out_token  out  TOKEN_W  token of the result

## Operation
- Buffer: DEPTH entries of {addr_k, addr_l, token}. Three pointers, each log2(DEPTH)+1 bits, wrap by natural overflow:
  - wr_ptr: next entry to write
  - iss_ptr: next entry to issue
  - ret_ptr: next entry to return
- count = wr_ptr − ret_ptr. `req_full` = (count == DEPTH), registered.
- Request handling:
  - `req_valid` while not full: write the entry at wr_ptr, then increment wr_ptr.
  - `req_valid` while full: drop the beat and set `err_overflow`. It clears only on reset.
- Issue FSM, states I_IDLE, I_K, I_L:
  - I_IDLE → I_K when iss_ptr ≠ wr_ptr. Drive `mem_rd_addr` = addr_k.
  - I_K → I_L on `mem_rd_valid & mem_rd_ready`. Drive `mem_rd_addr` = addr_l.
  - I_L → I_K on handshake, incrementing iss_ptr, if another entry is pending; otherwise → I_IDLE.
  - `mem_rd_valid` and `mem_rd_addr` stay stable until the handshake.
- Collect FSM, states C_K, C_L, C_OUT:
  - `mem_rsp_ready` = (state ≠ C_OUT).
  - C_K: a response is captured into `out_line_k`; → C_L.
  - C_L: a response is captured into `out_line_l`; `out_token` is loaded from the entry at ret_ptr; `out_valid` is set; → C_OUT.
  - C_OUT: on `out_valid & out_ready`, clear `out_valid`, increment ret_ptr, → C_K.
- A response arriving while `mem_rsp_ready` is low is a protocol violation. The memory side must honour `mem_rsp_ready`.
- Same-cycle request write and result pop: count is unchanged, so `req_full` is unchanged.
- Reset, including mid-transaction, returns every output to its reset value and restarts from an empty state:
  - all pointers 0; FSMs in I_IDLE and C_K
  - `mem_rd_valid`, `mem_rsp_ready`, `out_valid`, `req_full`, `err_overflow`: 0
  - `mem_rd_addr`, `out_line_k`, `out_line_l`, `out_token`: 0
  - `mem_rsp_ready` goes to 1 on the first clock after reset release.
  - Responses still in flight from before reset are the memory side's responsibility to flush.

## Timing
- All outputs are registered.
- Request accepted at cycle 0 → `mem_rd_valid` with addr_k at cycle 1. With `mem_rd_ready` held high, addr_l is presented at cycle 2.
- Second response at cycle n → `out_valid` at cycle n+1.
- Throughput with ready memory and downstream: one result per 2 commands, so one pair per 2 cycles on the command side.
- `req_full` rises the cycle after the DEPTH-th accept. It falls the cycle after the pop that frees an entry.

## Configuration
- SAME_LINE_MERGE_EN:
  - Defined: an entry whose addr_k == addr_l, compared at write and stored as a flag, issues only the K command and skips I_L. The collector copies the single response into both `out_line_k` and `out_line_l`, then goes to C_OUT.
  - Undefined: every entry issues two commands, even when the addresses are equal.

## Test plan
- Single request, addr_k=0x100, addr_l=0x240, memory ready with 3-cycle latency → commands 0x100 then 0x240; `out_line_k`/`out_line_l` equal the respective data; token echoed bit-exact.
- 8 back-to-back requests, `mem_rd_ready`=0 → `req_full`=1 after the 8th accept. A 9th `req_valid` sets `err_overflow`=1 and the buffer is unchanged. Releasing ready drains all 8 in order.
- `out_ready` held 0 for 20 cycles after the first result → `out_valid` and the data stay stable, `mem_rsp_ready`=0, no responses are lost; order is preserved after release.
- Pointer wrap: 40 requests with random stalls on both ready inputs → 40 results in request order; addresses and tokens match a scoreboard.
- Reset asserted while the issue FSM is in I_L with 3 entries pending → outputs go to 0 immediately; after release `req_full`=0, and a new request completes normally.
- addr_k = addr_l = 0x3C0:
  - with SAME_LINE_MERGE_EN: exactly 1 command, and both lines equal the response;
  - without it: 2 commands issued.
